// File: rtl/serial_nand_adder_seq.sv
// Bit-serial adder: one NAND-built full-adder cell walks the operands LSB first,
// one bit per clock, under an IDLE/SHIFT/DONE controller.
module serial_nand_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_mask;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_last;
  logic             w_accept;

  // Bit selection through a one-hot mask keeps the counter from ever acting as a raw index.
  assign w_mask   = WIDTH'(1) << r_cnt;
  assign w_a_bit  = |(r_a & w_mask);
  assign w_b_bit  = |(r_b & w_mask);
  assign w_last   = (r_cnt == LAST_BIT);
  assign w_accept = (r_state == IDLE) && start;

  // The single shared full-adder cell, nine two-input NANDs.
  logic w_n1, w_n2, w_n3, w_x1, w_n4, w_n5, w_n6, w_fa_sum, w_fa_cout;
  assign w_n1      = ~(w_a_bit & w_b_bit);
  assign w_n2      = ~(w_a_bit & w_n1);
  assign w_n3      = ~(w_b_bit & w_n1);
  assign w_x1      = ~(w_n2 & w_n3);
  assign w_n4      = ~(w_x1 & r_carry);
  assign w_n5      = ~(w_x1 & w_n4);
  assign w_n6      = ~(r_carry & w_n4);
  assign w_fa_sum  = ~(w_n5 & w_n6);
  assign w_fa_cout = ~(w_n4 & w_n1);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_sum   <= (r_sum & ~w_mask) | ({WIDTH{w_fa_sum}} & w_mask);
      r_carry <= w_fa_cout;
      if (w_last) begin
        // Overflow: carry into the sign bit disagrees with carry out of it.
        r_ovf <= r_carry ^ w_fa_cout;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_carry;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_nand_adder_seq.sv
// Self-checking bench: four widths share one stimulus bus; each lane has a
// timing model plus a result scoreboard, and directed tasks check the key scenarios.
module tb_serial_nand_adder_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        busy_w [4];
  logic        done_w [4];
  logic        cout_w [4];
  logic        ovf_w  [4];
  logic [31:0] sum_w  [4];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  always #5 clk = ~clk;

  function automatic res_t ref_add(int w, logic [31:0] x, logic [31:0] y, logic c);
    logic [32:0] mask;
    logic [32:0] full;
    res_t r;
    mask   = (33'd1 << w) - 33'd1;
    full   = (33'(x) & mask) + (33'(y) & mask) + 33'(c);
    r.sum  = 32'(full & mask);
    r.cout = full[w];
    r.ovf  = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]);
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 13 : 32;
    logic [W-1:0] w_sum;
    int   ph = 0;
    res_t q[$];
    res_t last = '0;

    serial_nand_adder_seq #(.WIDTH(W)) u_dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .a    (a[W-1:0]),
      .b    (b[W-1:0]),
      .cin  (cin),
      .busy (busy_w[g]),
      .done (done_w[g]),
      .sum  (w_sum),
      .cout (cout_w[g]),
      .ovf  (ovf_w[g])
    );
    assign sum_w[g] = 32'(w_sum);

    // Phase 0 = idle, 1..W = shifting, W+1 = done.
    always @(posedge clk) begin
      if (reset) begin
        ph = 0;
        q.delete();
        last = '0;
      end else if (ph == 0) begin
        if (start) begin
          q.push_back(ref_add(W, a, b, cin));
          ph = 1;
        end
      end else if (ph < W) begin
        ph = ph + 1;
      end else if (ph == W) begin
        if (q.size() > 0) last = q.pop_front();
        ph = W + 1;
      end else begin
        ph = 0;
      end
    end

    always @(negedge clk) begin
      n_total++;
      if (busy_w[g] !== (ph >= 1 && ph <= W) || done_w[g] !== (ph == W + 1))
        $display("FAIL sb_ctrl_w%0d t=%0t: busy=%b done=%b, expected busy=%b done=%b",
                 W, $time, busy_w[g], done_w[g], (ph >= 1 && ph <= W), (ph == W + 1));
      else n_pass++;
      if (ph == 0 || ph == W + 1) begin
        n_total++;
        if (sum_w[g] !== last.sum || cout_w[g] !== last.cout || ovf_w[g] !== last.ovf)
          $display("FAIL sb_result_w%0d t=%0t: sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   W, $time, sum_w[g], cout_w[g], ovf_w[g], last.sum, last.cout, last.ovf);
        else n_pass++;
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_w[0] && !busy_w[1] && !busy_w[2] && !busy_w[3] &&
          !done_w[0] && !done_w[1] && !done_w[2] && !done_w[3]) break;
    end
    n_total++;
    if (i == 100) $display("FAIL wait_idle: still busy after 100 cycles, expected idle");
    else n_pass++;
  endtask

  // Called at a falling edge; returns at the falling edge just after the accepting edge.
  task automatic pulse_start(logic [31:0] x, logic [31:0] y, logic c);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      n_total++;
      if (busy_w[g] !== 1'b0 || done_w[g] !== 1'b0 || sum_w[g] !== 32'd0 ||
          cout_w[g] !== 1'b0 || ovf_w[g] !== 1'b0)
        $display("FAIL reset_lane%0d: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                 g, busy_w[g], done_w[g], sum_w[g], cout_w[g], ovf_w[g]);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic run_op8(string name, logic [7:0] x, logic [7:0] y, logic c,
                         logic [7:0] es, logic ec, logic eo);
    wait_idle();
    pulse_start(32'(x), 32'(y), c);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (busy_w[0] !== 1'b1 || done_w[0] !== 1'b0)
        $display("FAIL %s_busy cycle %0d: busy=%b done=%b, expected busy=1 done=0",
                 name, i, busy_w[0], done_w[0]);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (done_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || sum_w[0] !== 32'(es) ||
        cout_w[0] !== ec || ovf_w[0] !== eo)
      $display("FAIL %s_done: done=%b busy=%b sum=%h cout=%b ovf=%b, expected done=1 busy=0 sum=%h cout=%b ovf=%b",
               name, done_w[0], busy_w[0], sum_w[0], cout_w[0], ovf_w[0], es, ec, eo);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0)
      $display("FAIL %s_idle: done=%b busy=%b, expected 0 0", name, done_w[0], busy_w[0]);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_op8("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_start();
    int nd = 0;
    wait_idle();
    pulse_start(32'h5A, 32'h33, 1'b0);
    for (int j = 0; j <= 12; j++) begin
      if (done_w[0] === 1'b1) nd++;
      if (j == 8) begin
        n_total++;
        if (done_w[0] !== 1'b1 || sum_w[0] !== 32'h8D || cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b1)
          $display("FAIL ignore_start_result: done=%b sum=%h cout=%b ovf=%b, expected 1 8d 0 1",
                   done_w[0], sum_w[0], cout_w[0], ovf_w[0]);
        else n_pass++;
      end
      if (j == 9) begin
        n_total++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0)
          $display("FAIL ignore_start_idle: busy=%b done=%b, expected 0 0", busy_w[0], done_w[0]);
        else n_pass++;
      end
      if (j == 2) begin a = '0; b = '0; start = 1'b1; end
      if (j == 3) start = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (nd != 1) $display("FAIL ignore_start_pulses: got %0d done pulses, expected 1", nd);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int nd = 0;
    wait_idle();
    pulse_start(32'h5A, 32'h33, 1'b0);
    for (int j = 0; j <= 15; j++) begin
      if (done_w[0] === 1'b1) nd++;
      if (j == 4) begin
        n_total++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || sum_w[0] !== 32'd0)
          $display("FAIL abort_state: busy=%b done=%b sum=%h, expected 0 0 00",
                   busy_w[0], done_w[0], sum_w[0]);
        else n_pass++;
      end
      if (j == 14) begin
        n_total++;
        if (done_w[0] !== 1'b1 || sum_w[0] !== 32'h02 || cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b0)
          $display("FAIL abort_restart: done=%b sum=%h cout=%b ovf=%b, expected 1 02 0 0",
                   done_w[0], sum_w[0], cout_w[0], ovf_w[0]);
        else n_pass++;
      end
      if (j == 3) reset = 1'b1;
      if (j == 4) reset = 1'b0;
      if (j == 5) begin a = 32'h1; b = 32'h1; cin = 1'b0; start = 1'b1; end
      if (j == 6) start = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (nd != 1) $display("FAIL abort_pulses: got %0d done pulses, expected 1", nd);
    else n_pass++;
  endtask

  task automatic test_width1();
    wait_idle();
    pulse_start(32'h1, 32'h1, 1'b1);
    n_total++;
    if (busy_w[1] !== 1'b1 || done_w[1] !== 1'b0)
      $display("FAIL w1_busy: busy=%b done=%b, expected 1 0", busy_w[1], done_w[1]);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done_w[1] !== 1'b1 || sum_w[1] !== 32'd1 || cout_w[1] !== 1'b1 || ovf_w[1] !== 1'b0)
      $display("FAIL w1_done: done=%b sum=%h cout=%b ovf=%b, expected 1 1 1 0",
               done_w[1], sum_w[1], cout_w[1], ovf_w[1]);
    else n_pass++;
    wait_idle();
    a = 32'h1; b = 32'h0; cin = 1'b0; start = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      n_total++;
      if (done_w[1] !== ((j % 3 == 1) && j <= 10))
        $display("FAIL w1_back_to_back cycle %0d: done=%b, expected %b",
                 j, done_w[1], ((j % 3 == 1) && j <= 10));
      else n_pass++;
      if (j == 11) start = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wait_idle();
      case (n % 8)
        0:       pulse_start('1, '1, 1'b1);
        1:       pulse_start(32'h8000_0000, 32'h8000_0000, 1'b0);
        default: pulse_start($urandom, $urandom, 1'($urandom_range(0, 1)));
      endcase
    end
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_abort();
    test_width1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
